// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: size encodings, FSM states,
// the latched request payload and byte-lane helpers.
package mem_stage_pkg;

  localparam int unsigned SEL_W  = 5;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned WORD_W = 32;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Everything captured from the execute stage when a memory op is accepted
  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              is_unsigned;
    logic              is_wb;
    logic [SEL_W-1:0]  write_sel;
    logic [BE_W-1:0]   be;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] pc;
  } mem_req_t;

  // Half accesses need bit 0 clear, word (and the 11 encoding) need both clear
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_B:   is_misaligned = 1'b0;
      MEM_H:   is_misaligned = off[0];
      MEM_W:   is_misaligned = (off != 2'b00);
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic logic [BE_W-1:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_B:   byte_enables = 4'b0001 << off;
      MEM_H:   byte_enables = 4'b0011 << off;
      default: byte_enables = 4'b1111;
    endcase
  endfunction

  // Replicate store data across every lane it could land in
  function automatic logic [WORD_W-1:0] store_lanes(input logic [1:0] size, input logic [WORD_W-1:0] d);
    case (size)
      MEM_B:   store_lanes = {4{d[7:0]}};
      MEM_H:   store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load extractor: selects the addressed byte/half/word from the
// read word and sign- or zero-extends it to 32 bits.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [WORD_W-1:0] rdata,
  input  logic [1:0]        addr,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [WORD_W-1:0] result_c
);

  logic [WORD_W-1:0] shifted;

  assign shifted = rdata >> {addr, 3'b000};

  // Pick the access width and extend
  always_comb begin
    result_c = shifted;
    case (size)
      MEM_B:   result_c = is_unsigned ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      MEM_H:   result_c = is_unsigned ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default: result_c = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores on a req/ack data port,
// stalls upstream while a transaction is outstanding, registers the cw_* bundle.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       ac_pc,
  input  logic [SEL_W-1:0]  ac_write_sel,
  input  logic              ac_is_load,
  input  logic              ac_is_store,
  input  logic              ac_is_wb,
  input  logic [DATA_W-1:0] ac_alu_result,
  input  logic [DATA_W-1:0] ac_store_data,
  input  logic [1:0]        ac_mem_size,
  input  logic              ac_mem_unsigned,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [BE_W-1:0]   dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic [31:0]       cw_pc,
  output logic              cw_is_wb,
  output logic [SEL_W-1:0]  cw_write_sel,
  output logic [DATA_W-1:0] cw_result,
  output logic              misalign_exc
);

  state_t            state;
  state_t            state_nxt;
  mem_req_t          lat;
  logic [ADDR_W-1:0] lat_addr;
  logic              mem_op;
  logic              misaligned;
  logic              capture;
  logic              complete;
  logic [WORD_W-1:0] load_val;

  assign mem_op     = ac_is_load | ac_is_store;
  assign misaligned = is_misaligned(ac_mem_size, ac_alu_result[1:0]);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, upstream stall and capture/complete strobes
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    capture   = 1'b0;
    complete  = 1'b0;
    if (state == IDLE) begin
      if (mem_op && !misaligned) begin
        stall     = 1'b1;
        capture   = 1'b1;
        state_nxt = BUSY;
      end
    end else begin
      stall = !dmem_ack;
      if (dmem_ack) begin
        complete  = 1'b1;
        state_nxt = IDLE;
      end
    end
  end

  // Latch the accepted request so the memory port stays stable until ack
  always_ff @(posedge clock) begin
    if (reset) begin
      lat      <= '0;
      lat_addr <= '0;
    end else if (capture) begin
      lat_addr <= ADDR_W'(ac_alu_result);
      lat      <= '{we:          ac_is_store,
                    size:        ac_mem_size,
                    is_unsigned: ac_mem_unsigned,
                    is_wb:       ac_is_wb,
                    write_sel:   ac_write_sel,
                    be:          byte_enables(ac_mem_size, ac_alu_result[1:0]),
                    wdata:       store_lanes(ac_mem_size, WORD_W'(ac_store_data)),
                    pc:          ac_pc};
    end
  end

  assign dmem_req   = (state == BUSY);
  assign dmem_we    = lat.we;
  assign dmem_addr  = {lat_addr[ADDR_W-1:2], 2'b00};
  assign dmem_be    = lat.be;
  assign dmem_wdata = DATA_W'(lat.wdata);

  load_align u_load_align (
    .rdata       (WORD_W'(dmem_rdata)),
    .addr        (lat_addr[1:0]),
    .size        (lat.size),
    .is_unsigned (lat.is_unsigned),
    .result_c    (load_val)
  );

  // Write-back bundle; cw_is_wb and misalign_exc default to a bubble each cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      cw_pc        <= '0;
      cw_is_wb     <= 1'b0;
      cw_write_sel <= '0;
      cw_result    <= '0;
      misalign_exc <= 1'b0;
    end else begin
      cw_is_wb     <= 1'b0;
      misalign_exc <= 1'b0;
      if (state == BUSY) begin
        if (complete) begin
          cw_pc        <= lat.pc;
          cw_write_sel <= lat.write_sel;
          if (!lat.we) begin
            cw_result <= DATA_W'(load_val);
            cw_is_wb  <= lat.is_wb && (lat.write_sel != '0);
          end
        end
      end else if (!mem_op) begin
        cw_pc        <= ac_pc;
        cw_write_sel <= ac_write_sel;
        cw_result    <= ac_alu_result;
        cw_is_wb     <= ac_is_wb && (ac_write_sel != '0);
      end else if (misaligned) begin
        cw_pc        <= ac_pc;
        cw_write_sel <= ac_write_sel;
        misalign_exc <= 1'b1;
      end
    end
  end

endmodule
